// File: rtl/hack_cpu_core.sv
// Hack-ISA execution core with its embedded Hack ALU.
// Executes one instruction per cycle from instruction ROM and holds its
// state while a data-memory access waits on mem_ready. A jump-to-self
// with an unconditional jump latches a sticky halt.

// Hack ALU: optional zero/negate on both operands, add or AND, optional output negate.
module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);
    logic [15:0] xs;
    logic [15:0] ys;
    logic [15:0] res;

    // Operand conditioning, function select and output negate.
    always_comb begin
        xs = x;
        if (zx) xs = '0;
        if (nx) xs = ~xs;
        ys = y;
        if (zy) ys = '0;
        if (ny) ys = ~ys;
        res = f ? (xs + ys) : (xs & ys);
        if (no) res = ~res;
        out = res;
    end

    assign zr = (out == '0);
    assign ng = out[15];
endmodule

module hack_cpu_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic [15:0] in_m,
    input  logic        mem_ready,
    output logic [15:0] out_m,
    output logic        write_m,
    output logic [14:0] addr_m,
    output logic [14:0] pc,
    output logic        halted
);
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [14:0] pc_reg;
    logic        halt_reg;

    logic        is_c;
    logic        sel_m;
    logic        dest_a;
    logic        dest_d;
    logic        dest_m;
    logic [2:0]  jmp;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        take;
    logic        needs_mem;
    logic        stall;
    logic        halt_hit;
    logic [14:0] pc_inc;
    logic        unused_bits;

    assign is_c   = instr[15];
    assign sel_m  = instr[12];
    assign dest_a = instr[5];
    assign dest_d = instr[4];
    assign dest_m = instr[3];
    assign jmp    = instr[2:0];

    // instr[14:13] are don't-care in C-instructions; A[15] never addresses anything.
    assign unused_bits = &{1'b0, instr[14:13], a_reg[15]};

    assign alu_y = sel_m ? in_m : a_reg;

    alu u_alu (
        .x  (d_reg),
        .y  (alu_y),
        .zx (instr[11]),
        .nx (instr[10]),
        .zy (instr[9]),
        .ny (instr[8]),
        .f  (instr[7]),
        .no (instr[6]),
        .out(alu_out),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    assign take      = is_c & ((jmp[2] & alu_ng) | (jmp[1] & alu_zr) | (jmp[0] & ~alu_ng & ~alu_zr));
    assign needs_mem = is_c & (sel_m | dest_m);
    assign stall     = needs_mem & ~mem_ready;
    assign halt_hit  = is_c & (jmp == 3'b111) & (a_reg[14:0] == pc_reg);
    assign pc_inc    = pc_reg + 15'd1;

    assign out_m   = alu_out;
    assign write_m = is_c & dest_m & ~halt_reg & rst_n;
    assign addr_m  = a_reg[14:0];
    assign pc      = pc_reg;
    assign halted  = halt_reg;

    // Architectural state update; frozen while stalled or halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            d_reg    <= '0;
            pc_reg   <= '0;
            halt_reg <= 1'b0;
        end else if (!halt_reg && !stall) begin
            if (!is_c) begin
                a_reg  <= {1'b0, instr[14:0]};
                pc_reg <= pc_inc;
            end else begin
                // PC target and halt compare both use the pre-edge A.
                if (dest_a) a_reg <= alu_out;
                if (dest_d) d_reg <= alu_out;
                pc_reg <= take ? a_reg[14:0] : pc_inc;
                if (halt_hit) halt_reg <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hack_cpu_core.sv
// Self-checking bench for hack_cpu_core: directed vector table, hand-written
// stall/halt/wrap/reset sequences and a randomized run against a reference model.
module tb_hack_cpu_core;
    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic [15:0] in_m;
    logic        mem_ready;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] addr_m;
    logic [14:0] pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    hack_cpu_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .in_m     (in_m),
        .mem_ready(mem_ready),
        .out_m    (out_m),
        .write_m  (write_m),
        .addr_m   (addr_m),
        .pc       (pc),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] in_m;
        logic        ready;
        logic        chk_out;
        logic [15:0] exp_out;
        logic        exp_write;
        logic [14:0] exp_addr;
        logic [14:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int unsigned m_a, m_d, m_pc;
    bit m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [15:0] i, input logic [15:0] m, input logic r);
        instr = i;
        in_m = m;
        mem_ready = r;
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(16'hE308, 16'h0, 1'b1);
        @(negedge clk);
        chk("rst_pc", {17'b0, pc}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_write", {31'b0, write_m}, 32'd0);
        chk("rst_addr", {17'b0, addr_m}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_a = 0; m_d = 0; m_pc = 0; m_halt = 0;
    endtask

    function automatic void mk(input logic [15:0] i, input logic r, input logic co, input logic [15:0] eo,
                               input logic ew, input logic [14:0] ea, input logic [14:0] ep);
        vec_t v;
        v.instr = i; v.in_m = 16'h0; v.ready = r; v.chk_out = co; v.exp_out = eo;
        v.exp_write = ew; v.exp_addr = ea; v.exp_pc = ep;
        vecs.push_back(v);
    endfunction

    // Hack ALU from its definition, in plain integer arithmetic.
    function automatic int unsigned alu_ref(input int unsigned x, input int unsigned y, input logic [5:0] c);
        int unsigned r;
        if (c[5]) x = 0;
        if (c[4]) x = 65535 - x;
        if (c[3]) y = 0;
        if (c[2]) y = 65535 - y;
        r = c[1] ? (x + y) % 65536 : (x & y);
        if (c[0]) r = 65535 - r;
        return r;
    endfunction

    initial begin
        logic [15:0] ri;
        logic [15:0] rm;
        logic        rr;
        int unsigned exp_out, yv, cur_pc;
        bit          is_c, exp_w, stall, take, hit;
        int          sval;
        int          halt_cnt;

        rst_n = 1'b0;
        set_in(16'h0, 16'h0, 1'b0);
        #2;

        // ---------------- Directed table ----------------
        mk(16'h0005, 1, 0, 16'h0000, 0, 15'h0000, 15'd0);   // @5
        mk(16'hEC10, 1, 1, 16'h0005, 0, 15'h0005, 15'd1);   // D=A
        mk(16'h0007, 1, 0, 16'h0000, 0, 15'h0005, 15'd2);   // @7
        mk(16'hE090, 1, 1, 16'h000C, 0, 15'h0007, 15'd3);   // D=D+A
        mk(16'h0010, 1, 0, 16'h0000, 0, 15'h0007, 15'd4);   // @16
        mk(16'hE308, 1, 1, 16'h000C, 1, 15'h0010, 15'd5);   // M=D
        mk(16'hEFD0, 0, 1, 16'h0001, 0, 15'h0010, 15'd6);   // D=1, ready low
        mk(16'hEE90, 0, 1, 16'hFFFF, 0, 15'h0010, 15'd7);   // D=-1, ready low
        mk(16'h0003, 0, 0, 16'h0000, 0, 15'h0010, 15'd8);   // @3
        mk(16'hECD0, 1, 1, 16'hFFFD, 0, 15'h0003, 15'd9);   // D=-A
        mk(16'h0014, 1, 0, 16'h0000, 0, 15'h0003, 15'd10);  // @20
        mk(16'hE304, 1, 1, 16'hFFFD, 0, 15'h0014, 15'd11);  // D;JLT taken
        mk(16'hE301, 1, 1, 16'hFFFD, 0, 15'h0014, 15'd20);  // D;JGT not taken
        mk(16'hEA90, 1, 1, 16'h0000, 0, 15'h0014, 15'd21);  // D=0
        mk(16'hE302, 1, 1, 16'h0000, 0, 15'h0014, 15'd22);  // D;JEQ taken
        mk(16'h0000, 1, 0, 16'h0000, 0, 15'h0014, 15'd20);  // landed at 20

        do_reset();
        foreach (vecs[k]) begin
            set_in(vecs[k].instr, vecs[k].in_m, vecs[k].ready);
            @(negedge clk);
            chk($sformatf("vec%0d_pc", k), {17'b0, pc}, {17'b0, vecs[k].exp_pc});
            chk($sformatf("vec%0d_addr", k), {17'b0, addr_m}, {17'b0, vecs[k].exp_addr});
            chk($sformatf("vec%0d_write", k), {31'b0, write_m}, {31'b0, vecs[k].exp_write});
            if (vecs[k].chk_out)
                chk($sformatf("vec%0d_out", k), {16'b0, out_m}, {16'b0, vecs[k].exp_out});
            tick();
        end

        // ---------------- PC wrap ----------------
        do_reset();
        set_in(16'h7FFF, 0, 1); tick();           // @0x7FFF
        set_in(16'hEA87, 0, 1); tick();           // 0;JMP
        @(negedge clk);
        chk("wrap_pre", {17'b0, pc}, 32'h7FFF);
        set_in(16'h0001, 0, 0); tick();           // non-jump at 0x7FFF
        @(negedge clk);
        chk("wrap_post", {17'b0, pc}, 32'd0);

        // ---------------- Stall on store and load ----------------
        do_reset();
        set_in(16'h0100, 0, 1); tick();           // @0x100
        for (int unsigned c = 0; c < 4; c++) begin
            set_in(16'hE7C8, 0, (c == 3));        // M=D+1
            @(negedge clk);
            chk($sformatf("stall%0d_pc", c), {17'b0, pc}, 32'd1);
            chk($sformatf("stall%0d_write", c), {31'b0, write_m}, 32'd1);
            chk($sformatf("stall%0d_addr", c), {17'b0, addr_m}, 32'h100);
            chk($sformatf("stall%0d_out", c), {16'b0, out_m}, 32'd1);
            tick();
        end
        @(negedge clk);
        chk("stall_release_pc", {17'b0, pc}, 32'd2);
        for (int unsigned c = 0; c < 2; c++) begin
            set_in(16'hFC10, 16'h1234, 0);        // D=M, stalled
            @(negedge clk);
            chk("load_out", {16'b0, out_m}, 32'h1234);
            tick();
        end
        set_in(16'hE300, 16'h1234, 0);            // D (register only, never stalls)
        @(negedge clk);
        chk("load_pc_held", {17'b0, pc}, 32'd2);
        chk("load_d_held", {16'b0, out_m}, 32'd0);
        tick();
        @(negedge clk);
        chk("regop_nostall", {17'b0, pc}, 32'd3);

        // ---------------- Halt, deferred by stall ----------------
        do_reset();
        for (int unsigned c = 0; c < 8; c++) begin
            set_in(16'h0000, 0, 1); tick();
        end
        set_in(16'h0009, 0, 1); tick();           // @9 at pc 8
        set_in(16'hEA8F, 0, 0);                   // M=0;JMP at pc 9, stalled
        @(negedge clk);
        chk("halt_pre_pc", {17'b0, pc}, 32'd9);
        tick();
        @(negedge clk);
        chk("halt_deferred", {31'b0, halted}, 32'd0);
        chk("halt_def_write", {31'b0, write_m}, 32'd1);
        mem_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("halt_set", {31'b0, halted}, 32'd1);
        chk("halt_pc", {17'b0, pc}, 32'd9);
        for (int unsigned c = 0; c < 10; c++) begin
            set_in(16'($urandom()) | 16'h0008, 16'($urandom()), 1'($urandom()));
            @(negedge clk);
            chk($sformatf("halted%0d_flag", c), {31'b0, halted}, 32'd1);
            chk($sformatf("halted%0d_pc", c), {17'b0, pc}, 32'd9);
            chk($sformatf("halted%0d_write", c), {31'b0, write_m}, 32'd0);
            tick();
        end

        // ---------------- Async reset during stalled store ----------------
        do_reset();
        set_in(16'h0100, 0, 1); tick();
        set_in(16'hE7C8, 0, 0);
        @(negedge clk);
        chk("arst_pre_write", {31'b0, write_m}, 32'd1);
        chk("arst_pre_pc", {17'b0, pc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", {17'b0, pc}, 32'd0);
        chk("arst_write", {31'b0, write_m}, 32'd0);
        chk("arst_halted", {31'b0, halted}, 32'd0);
        tick();
        rst_n = 1'b1;
        set_in(16'h0000, 0, 1);
        @(negedge clk);
        chk("arst_restart0", {17'b0, pc}, 32'd0);
        tick();
        @(negedge clk);
        chk("arst_restart1", {17'b0, pc}, 32'd1);

        // ---------------- Randomized run against model ----------------
        do_reset();
        halt_cnt = 0;
        for (int unsigned n = 0; n < 3000; n++) begin
            if (m_halt) halt_cnt++;
            if (halt_cnt > 4) begin
                do_reset();
                halt_cnt = 0;
            end
            if ($urandom_range(1, 0) == 0) ri = {1'b0, 15'($urandom_range(40, 0))};
            else                           ri = {3'b111, 13'($urandom())};
            rm = 16'($urandom());
            rr = ($urandom_range(9, 0) < 7);
            set_in(ri, rm, rr);

            is_c    = ri[15];
            yv      = (is_c && ri[12]) ? int'(rm) : m_a;
            exp_out = alu_ref(m_d, yv, ri[11:6]);
            exp_w   = is_c && ri[3] && !m_halt;
            stall   = is_c && (ri[12] || ri[3]) && !rr;

            @(negedge clk);
            chk("rnd_out", {16'b0, out_m}, exp_out);
            chk("rnd_write", {31'b0, write_m}, {31'b0, exp_w});
            chk("rnd_addr", {17'b0, addr_m}, m_a % 32768);
            chk("rnd_pc", {17'b0, pc}, m_pc);
            chk("rnd_halted", {31'b0, halted}, {31'b0, m_halt});
            tick();

            if (!m_halt && !stall) begin
                cur_pc = m_pc;
                if (!is_c) begin
                    m_a  = ri % 32768;
                    m_pc = (m_pc + 1) % 32768;
                end else begin
                    sval = (exp_out >= 32768) ? int'(exp_out) - 65536 : int'(exp_out);
                    take = (ri[2] && sval < 0) || (ri[1] && sval == 0) || (ri[0] && sval > 0);
                    hit  = (ri[2:0] == 3'b111) && ((m_a % 32768) == cur_pc);
                    m_pc = take ? m_a % 32768 : (m_pc + 1) % 32768;
                    if (ri[5]) m_a = exp_out;
                    if (ri[4]) m_d = exp_out;
                    if (hit) m_halt = 1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
